// File: rtl/sram_addr_tx_pkg.sv
// Shared definitions for the SRAM address serial transmitter:
// state encoding and default geometry.
package sram_addr_tx_pkg;
    localparam int ADDR_W_DEF  = 21;
    localparam int CLK_DIV_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_TAIL,
        S_DONE
    } state_e;
endpackage

// File: rtl/sram_addr_tx_clk_div_tick.sv
// Reloadable CLK_DIV down-counter. o_tick marks the last cycle of each
// CLK_DIV-cycle interval; i_restart starts a fresh interval.
module clk_div_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_restart || (r_cnt == '0))
            r_cnt <= RELOAD;
        else
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_tick = (r_cnt == '0) && !i_restart;
endmodule

// File: rtl/sram_addr_tx.sv
// Serialises a parallel SRAM address onto the CPLD shift pins (MSB first),
// with a one-entry cache that lets repeated addresses skip the shift.
module sram_addr_tx
    import sram_addr_tx_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int HIT_SKIP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              sreg_en,
    output logic              sclk,
    output logic              sdata
);
    localparam int BW = $clog2(ADDR_W);

    state_e            r_state, w_next;
    logic [ADDR_W-1:0] r_shift, r_addr, r_cache;
    logic              r_cvalid;
    logic [BW-1:0]     r_bit;
    logic              w_accept, w_hit, w_tick, w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    // flush in the same cycle as start must force a real shift
    assign w_hit    = (HIT_SKIP != 0) && r_cvalid && !flush && (addr == r_cache);
    assign w_last   = (r_bit == '0);

    clk_div_tick #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .reset    (reset),
        .i_restart(w_accept),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_hit ? S_DONE : S_LOW;
            S_LOW:  if (w_tick)   w_next = S_HIGH;
            S_HIGH: if (w_tick)   w_next = w_last ? S_TAIL : S_LOW;
            S_TAIL: if (w_tick)   w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift  <= '0;
            r_addr   <= '0;
            r_cache  <= '0;
            r_cvalid <= 1'b0;
            r_bit    <= '0;
        end else begin
            if ((r_state == S_IDLE) && flush)
                r_cvalid <= 1'b0;
            if (w_accept) begin
                r_shift <= addr;
                r_addr  <= addr;
                r_bit   <= BW'(ADDR_W - 1);
            end
            // next bit is presented only after the full HIGH phase
            if ((r_state == S_HIGH) && w_tick && !w_last) begin
                r_shift <= {r_shift[ADDR_W-2:0], 1'b0};
                r_bit   <= r_bit - 1'b1;
            end
            if (r_state == S_DONE) begin
                r_cache  <= r_addr;
                r_cvalid <= 1'b1;
            end
        end
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        sreg_en = 1'b1;
        sclk    = 1'b0;
        sdata   = 1'b0;
        case (r_state)
            S_LOW: begin
                busy    = 1'b1;
                sreg_en = 1'b0;
                sdata   = r_shift[ADDR_W-1];
            end
            S_HIGH: begin
                busy    = 1'b1;
                sreg_en = 1'b0;
                sclk    = 1'b1;
                sdata   = r_shift[ADDR_W-1];
            end
            S_TAIL: begin
                busy    = 1'b1;
                sreg_en = 1'b0;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sram_addr_tx.sv
// Bench for sram_addr_tx: two instances (CLK_DIV=2 and CLK_DIV=1) checked
// every cycle against a timeline model, plus a CPLD shift-register model.
module tb_sram_addr_tx;
    localparam int W = 21;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic         st[2];
    logic         fl[2];
    logic [W-1:0] ad[2];
    logic         busy[2], done[2], sen[2], sclk[2], sdata[2];

    sram_addr_tx #(.ADDR_W(W), .CLK_DIV(2), .HIT_SKIP(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(st[0]), .addr(ad[0]), .flush(fl[0]),
        .busy(busy[0]), .done(done[0]), .sreg_en(sen[0]), .sclk(sclk[0]), .sdata(sdata[0])
    );
    sram_addr_tx #(.ADDR_W(W), .CLK_DIV(1), .HIT_SKIP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(st[1]), .addr(ad[1]), .flush(fl[1]),
        .busy(busy[1]), .done(done[1]), .sreg_en(sen[1]), .sclk(sclk[1]), .sdata(sdata[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // CPLD shift register: samples sdata on sclk rising edges while enabled
    logic [W-1:0] cpld[2];
    int           nedge[2];
    initial begin
        cpld[0] = '0; cpld[1] = '0;
        nedge[0] = 0; nedge[1] = 0;
    end
    always @(posedge sclk[0]) if (!sen[0]) begin cpld[0] = {cpld[0][W-2:0], sdata[0]}; nedge[0]++; end
    always @(posedge sclk[1]) if (!sen[1]) begin cpld[1] = {cpld[1][W-2:0], sdata[1]}; nedge[1]++; end

    // Timeline model: a shift occupies 2*D*W + D busy cycles, done follows
    int           D[2] = '{2, 1};
    bit           m_shift[2], m_hit[2], m_cv[2];
    int           m_k[2];
    logic [W-1:0] m_addr[2], m_cache[2];

    function automatic int tlat(input int j);
        return 2 * D[j] * W + D[j] + 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < 2; j++) begin
                m_shift[j] = 0; m_hit[j] = 0; m_cv[j] = 0; m_k[j] = 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (m_hit[j]) begin
                    m_hit[j] = 0; m_cache[j] = m_addr[j]; m_cv[j] = 1;
                end else if (m_shift[j]) begin
                    if (m_k[j] == tlat(j)) begin
                        m_shift[j] = 0; m_cache[j] = m_addr[j]; m_cv[j] = 1;
                    end else
                        m_k[j]++;
                end else if (st[j]) begin
                    if (fl[j]) m_cv[j] = 0;
                    m_addr[j] = ad[j];
                    if (m_cv[j] && ad[j] == m_cache[j]) m_hit[j] = 1;
                    else begin m_shift[j] = 1; m_k[j] = 1; end
                end else if (fl[j])
                    m_cv[j] = 0;
            end
        end
    end

    // Compare process: outputs packed as {busy, done, sreg_en, sclk, sdata}
    always @(negedge clk) begin
        int k, bi, ph;
        logic [4:0] e, a;
        bit cs;
        if (reset) begin
            for (int j = 0; j < 2; j++) begin
                cs = 1;
                e = 5'b00100;
                if (m_hit[j]) begin
                    e = 5'b01100; cs = 0;
                end else if (m_shift[j]) begin
                    k = m_k[j];
                    if (k <= 2 * D[j] * W) begin
                        bi = (k - 1) / (2 * D[j]);
                        ph = (k - 1) % (2 * D[j]);
                        e = {3'b100, (ph >= D[j]), m_addr[j][W-1-bi]};
                    end else if (k <= 2 * D[j] * W + D[j]) begin
                        e = 5'b10000; cs = 0;
                    end else begin
                        e = 5'b01100; cs = 0;
                    end
                end
                a = {busy[j], done[j], sen[j], sclk[j], cs ? sdata[j] : 1'b0};
                chk($sformatf("cycle outputs dut%0d t=%0t", j, $time), {27'd0, a}, {27'd0, e});
            end
        end
    end

    task automatic run_req(input int j, input logic [W-1:0] a, input logic f,
                           input int coll, input int exp_lat, input string nm);
        int e0, c;
        logic [W-1:0] cp0;
        e0 = nedge[j]; cp0 = cpld[j];
        st[j] = 1'b1; ad[j] = a; fl[j] = f;
        @(posedge clk); #1;
        st[j] = 1'b0; fl[j] = 1'b0; ad[j] = W'($urandom);
        for (c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (done[j] === 1'b1) break;
            @(posedge clk); #1;
            st[j] = (c + 1 == coll);
            ad[j] = (c + 1 == coll) ? {W{1'b1}} : W'($urandom);
        end
        @(posedge clk); #1;
        st[j] = 1'b0;
        chk({nm, " latency"}, c, exp_lat);
        if (exp_lat == 1) begin
            chk({nm, " sclk edges"}, nedge[j] - e0, 0);
            chk({nm, " cpld value"}, {11'd0, cpld[j]}, {11'd0, cp0});
        end else begin
            chk({nm, " sclk edges"}, nedge[j] - e0, W);
            chk({nm, " cpld value"}, {11'd0, cpld[j]}, {11'd0, a});
        end
    endtask

    initial begin
        int j, e0, lat;
        logic [W-1:0] a;
        logic f;
        for (int i = 0; i < 2; i++) begin st[i] = 0; fl[i] = 0; ad[i] = '0; end
        #1;
        chk("reset outputs dut0", {27'd0, busy[0], done[0], sen[0], sclk[0], sdata[0]}, 32'b00100);
        chk("reset outputs dut1", {27'd0, busy[1], done[1], sen[1], sclk[1], sdata[1]}, 32'b00100);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_req(0, 21'h15A5A3, 0, 0, 87, "basic");
        run_req(0, 21'h15A5A3, 0, 0, 1, "cache hit");
        fl[0] = 1'b1; @(posedge clk); #1; fl[0] = 1'b0;
        run_req(0, 21'h15A5A3, 0, 0, 87, "after flush");
        run_req(0, 21'h15A5A3, 1, 0, 87, "flush with start");
        run_req(0, 21'h000001, 0, 10, 87, "busy collision");
        repeat (3) @(posedge clk);
        #1;

        // reset during bit 7 (cycle 30 after acceptance with CLK_DIV=2)
        run_req(0, 21'h0ABCDE, 0, 0, 87, "pre-reset");
        e0 = nedge[0];
        st[0] = 1'b1; ad[0] = 21'h013579;
        @(posedge clk); #1; st[0] = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("edges before reset", nedge[0] - e0, 7);
        #2 reset = 1'b0;
        #1;
        chk("async reset outputs", {27'd0, busy[0], done[0], sen[0], sclk[0], sdata[0]}, 32'b00100);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        run_req(0, 21'h0ABCDE, 0, 0, 87, "post-reset refetch");

        run_req(1, 21'h000000, 0, 0, 44, "div1 zero");
        run_req(1, 21'h1FFFFF, 0, 0, 44, "div1 ones");
        run_req(1, 21'h1FFFFF, 0, 0, 1, "div1 hit");

        for (int it = 0; it < 24; it++) begin
            j = it % 2;
            if ($urandom_range(3) == 0) begin
                fl[j] = 1'b1; @(posedge clk); #1; fl[j] = 1'b0;
            end
            a = ($urandom_range(1) == 1) ? m_cache[j] : W'($urandom);
            f = ($urandom_range(4) == 0);
            lat = (m_cv[j] && a == m_cache[j] && !f) ? 1 : tlat(j);
            run_req(j, a, f, 0, lat, $sformatf("random %0d", it));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_addr_tx.md
Name: sram_addr_tx

Overview:
Serial address transmitter for the SRAM address shift register in the CPLD. It takes a parallel SRAM address and serialises it onto the CPLD's shift-data, shift-clock and shift-enable pins. It sits on the host side of the link, either in the AVR-replacement FPGA host logic or in the synthesisable bench master. It includes a one-entry address cache so that repeated accesses to the same address skip the shift.

Parameters:
ADDR_W, 21, address width; must equal the CPLD sram_addr width.
CLK_DIV, 2, clk cycles per half shift-clock period (1..255).
HIT_SKIP, 1, when 1, a request to the cached address completes without shifting.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  request pulse; sampled only when busy=0.
addr  in  ADDR_W  address to send; captured when start is accepted.
flush  in  1  invalidates the address cache.
busy  out  1  high while a shift is in progress.
done  out  1  one-cycle pulse when the address is loaded (or on a cache hit).
sreg_en  out  1  active-low shift enable; the CPLD gates the shift clock while this is low.
sclk  out  1  shift clock; the CPLD samples sdata on its rising edge.
sdata  out  1  serial data, MSB first.

Behaviour:
- Reset (asynchronous, reset=0), applied at any time including mid-shift:
  - sreg_en=1, sclk=0, sdata=0, busy=0, done=0.
  - State IDLE, cache invalid, counters 0.
  - A partially shifted CPLD address is left as-is; the next request always performs a full shift.
- States: IDLE, LOW, HIGH, TAIL, DONE. A bit counter counts down from ADDR_W-1; a divider counts CLK_DIV-1 down to 0.
- IDLE, start=1 accepted:
  - Capture addr into shift_reg.
  - On a cache hit (HIT_SKIP=1, cache valid, addr==cached): go to DONE; no pin activity.
  - Otherwise: go to LOW, drive sreg_en=0, busy=1, sdata=addr[ADDR_W-1].
- LOW (CLK_DIV cycles): sclk=0 and sdata holds the current bit. Then go to HIGH.
- HIGH (CLK_DIV cycles): sclk=1 and sdata is unchanged, so data is stable across the rising edge.
  - After the last cycle, if bits remain: shift left, present the next bit, go to LOW.
  - Otherwise go to TAIL.
- TAIL (CLK_DIV cycles): sclk=0, sreg_en=0. Then go to DONE with sreg_en=1.
- sreg_en changes only while sclk=0, so the CPLD's gated clock never sees a runt pulse.
- DONE (1 cycle):
  - done=1, busy=0.
  - Cache <= captured address, cache valid <= 1.
  - Next state is IDLE.
  - start is not accepted in this cycle.
- Latency:
  - Shift path: busy is high for 2*CLK_DIV*ADDR_W + CLK_DIV cycles, then done follows. Defaults: 86 busy cycles, done in cycle 87 after acceptance.
  - Cache hit: done in the cycle after acceptance, busy never asserts.
- Exactly ADDR_W rising edges on sclk per shift. The last bit sent is addr[0].
- start while busy=1 or during DONE is ignored; there is no queuing and no error flag.
- flush:
  - In IDLE, flush=1 clears cache valid.
  - flush asserted together with start in the same cycle: flush takes priority, so the request always shifts.
  - flush during a shift: the cache is still written in DONE, because the new address is genuinely loaded.
- addr changes after acceptance have no effect on the transfer in progress.

Decomposition:
- Shared package holds the state encoding enum, ADDR_W default (21) and CLK_DIV default.
- One sub-module, clk_div_tick: a CLK_DIV down-counter that pulses at terminal count and reloads on restart. It is reusable by the bus_fsm timing.
- The FSM, shift register and cache stay in sram_addr_tx.

Test Plan:
- Basic shift: reset, then start with addr=0x15A5A3 -> 21 sclk rising edges; sdata sampled on them reads 1,0,1,0,1,... MSB first; a bench model of the CPLD shift register holds 0x15A5A3; done pulses 87 cycles after acceptance; sreg_en low for 86 cycles.
- Cache hit: repeat addr=0x15A5A3 -> done in the next cycle, no sclk edges, sreg_en stays 1. Then flush and repeat -> full 86-cycle shift.
- Busy collision: start with addr=0x000001, then pulse start with addr=0x1FFFFF at cycle 10 -> ignored; model holds 0x000001; exactly one done pulse.
- Reset mid-shift: assert reset at bit 7 -> outputs go idle within the same cycle (asynchronous). A subsequent start with the previous address performs a full shift (cache invalid).
- Boundaries: addr=0x000000 and addr=0x1FFFFF with CLK_DIV=1 -> 43 busy cycles, the model holds the exact value, sclk is high for exactly 1 cycle per bit, and sreg_en never toggles while sclk=1.
